iterative_alu: RTL and testbench



---
 rtl/iterative_alu.sv | 236 +++++++++++++++++++++++
 tb/tb_iterative_alu.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/iterative_alu.sv
// iterative_alu: handshaked ADD/SUB/MUL/DIV/MOD with WIDTH-step shift-add multiply and restoring divide.
// Optional macro ITER_ALU_OPCODE_ERR_EN: flag unsupported opcodes on error[2].
module iterative_alu #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     inputA,
  input  logic [WIDTH-1:0]     inputB,
  input  logic [3:0]           op_code,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   R,
  output logic [2:0]           error
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_DIV = 4'b0010;
  localparam logic [3:0] OP_MOD = 4'b0001;

`ifdef ITER_ALU_OPCODE_ERR_EN
  localparam logic [2:0] UNSUP_ERR = 3'b100;
`else
  localparam logic [2:0] UNSUP_ERR = 3'b000;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // MUL always iterates; DIV/MOD iterate only with a non-zero divisor.
  function automatic logic needs_iter(input logic [3:0] op, input logic [WIDTH-1:0] b);
    return (op == OP_MUL) || (((op == OP_DIV) || (op == OP_MOD)) && (b != {WIDTH{1'b0}}));
  endfunction

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [WIDTH-1:0]       a_r;
  logic [WIDTH-1:0]       b_r;
  logic [3:0]             op_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [2*WIDTH-1:0]     work_r;
  logic [2*WIDTH-1:0]     result_r;
  logic [2:0]             error_r;
  logic                   out_valid_r;
  logic                   in_ready_r;

  logic                   accept_s;
  logic                   step_s;
  logic                   load_s;
  logic                   retire_s;

  logic                   sub_s;
  logic [WIDTH-1:0]       b_eff_s;
  logic [WIDTH:0]         sum_s;
  logic                   ovf_s;

  logic [WIDTH:0]         mul_sum_s;
  logic [2*WIDTH-1:0]     mul_nxt_s;
  logic [WIDTH:0]         div_shift_s;
  logic [WIDTH:0]         div_diff_s;
  logic [2*WIDTH-1:0]     div_nxt_s;

  logic [2*WIDTH-1:0]     result_s;
  logic [2:0]             error_s;

  // Add/subtract datapath; overflow is carry-into-MSB xor carry-out-of-MSB.
  always_comb begin
    sub_s   = (op_r == OP_SUB);
    b_eff_s = sub_s ? ~b_r : b_r;
    sum_s   = {1'b0, a_r} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, sub_s};
    ovf_s   = (sum_s[WIDTH-1] ^ a_r[WIDTH-1] ^ b_eff_s[WIDTH-1]) ^ sum_s[WIDTH];
  end

  // One shift-add multiply step and one restoring divide step; work_r holds {hi, lo}.
  always_comb begin
    mul_sum_s   = {1'b0, work_r[2*WIDTH-1:WIDTH]}
                + (work_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
    mul_nxt_s   = {mul_sum_s, work_r[WIDTH-1:1]};
    div_shift_s = {work_r[2*WIDTH-1:WIDTH], work_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, b_r};
    if (div_diff_s[WIDTH]) begin
      div_nxt_s = {div_shift_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b0};
    end else begin
      div_nxt_s = {div_diff_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b1};
    end
  end

  // Final result and error selection, loaded on the first DONE cycle.
  always_comb begin
    result_s = {(2*WIDTH){1'b0}};
    error_s  = 3'b000;
    case (op_r)
      OP_ADD, OP_SUB: begin
        result_s = {{WIDTH{sum_s[WIDTH-1]}}, sum_s[WIDTH-1:0]};
        error_s  = {2'b00, ovf_s};
      end
      OP_MUL: begin
        result_s = work_r;
      end
      OP_DIV: begin
        if (b_r == {WIDTH{1'b0}}) begin
          result_s = {(2*WIDTH){1'b1}};
          error_s  = 3'b010;
        end else begin
          result_s = {{WIDTH{1'b0}}, work_r[WIDTH-1:0]};
        end
      end
      OP_MOD: begin
        if (b_r == {WIDTH{1'b0}}) begin
          result_s = {(2*WIDTH){1'b1}};
          error_s  = 3'b010;
        end else begin
          result_s = {{WIDTH{1'b0}}, work_r[2*WIDTH-1:WIDTH]};
        end
      end
      default: begin
        result_s = {(2*WIDTH){1'b0}};
        error_s  = UNSUP_ERR;
      end
    endcase
  end

  // Next-state and control strobes.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    step_s      = 1'b0;
    load_s      = 1'b0;
    retire_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid && in_ready_r) begin
          accept_s = 1'b1;
          if (needs_iter(op_code, inputB)) begin
            state_nxt_s = ST_EXEC;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        step_s = 1'b1;
        // Counter reaches WIDTH on this edge.
        if (cnt_r == CNT_W'(WIDTH - 1)) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      ST_DONE: begin
        if (!out_valid_r) begin
          load_s      = 1'b1;
          state_nxt_s = ST_DONE;
        end else if (out_ready) begin
          retire_s    = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture and iterative datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r    <= {WIDTH{1'b0}};
      b_r    <= {WIDTH{1'b0}};
      op_r   <= 4'b0000;
      cnt_r  <= {CNT_W{1'b0}};
      work_r <= {(2*WIDTH){1'b0}};
    end else if (accept_s) begin
      a_r    <= inputA;
      b_r    <= inputB;
      op_r   <= op_code;
      cnt_r  <= {CNT_W{1'b0}};
      work_r <= {{WIDTH{1'b0}}, inputA};
    end else if (step_s) begin
      cnt_r  <= cnt_r + CNT_W'(1);
      work_r <= (op_r == OP_MUL) ? mul_nxt_s : div_nxt_s;
    end else begin
      cnt_r  <= cnt_r;
      work_r <= work_r;
    end
  end

  // Registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      result_r    <= {(2*WIDTH){1'b0}};
      error_r     <= 3'b000;
    end else begin
      in_ready_r <= (state_nxt_s == ST_IDLE);
      if (load_s) begin
        out_valid_r <= 1'b1;
        result_r    <= result_s;
        error_r     <= error_s;
      end else if (retire_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign R         = result_r;
  assign error     = error_r;

endmodule

// File: tb/tb_iterative_alu.sv
// Self-checking bench for iterative_alu (WIDTH=16): vector table, random ops vs arithmetic model, corner sequences.
module tb_iterative_alu;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a_in;
  logic [W-1:0]   b_in;
  logic [3:0]     op_in;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] r_out;
  logic [2:0]     err_out;

  int errors = 0;
  int checks = 0;

`ifdef ITER_ALU_OPCODE_ERR_EN
  localparam logic [2:0] UNSUP = 3'b100;
`else
  localparam logic [2:0] UNSUP = 3'b000;
`endif

  iterative_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inputA(a_in), .inputB(b_in), .op_code(op_in),
    .out_valid(out_valid), .out_ready(out_ready), .R(r_out), .error(err_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] r;
    logic [2:0]     e;
    int             lat;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Arithmetic reference model written from the operation rules.
  function automatic void ref_model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [2*W-1:0] r, output logic [2:0] e, output int lat);
    logic [W-1:0] s;
    r = '0; e = 3'b000; lat = 1;
    case (op)
      4'b0000: begin
        s = a + b;
        r = {{W{s[W-1]}}, s};
        e = {2'b00, (a[W-1] == b[W-1]) && (s[W-1] != a[W-1])};
      end
      4'b1000: begin
        s = a - b;
        r = {{W{s[W-1]}}, s};
        e = {2'b00, (a[W-1] != b[W-1]) && (s[W-1] != a[W-1])};
      end
      4'b0100: begin
        r = (2*W)'(a) * (2*W)'(b);
        lat = W + 1;
      end
      4'b0010, 4'b0001: begin
        if (b == 0) begin
          r = '1; e = 3'b010;
        end else begin
          r = (op == 4'b0010) ? (2*W)'(a / b) : (2*W)'(a % b);
          lat = W + 1;
        end
      end
      default: e = UNSUP;
    endcase
  endfunction

  // Issue one operation, measure latency, then retire it.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [2*W-1:0] res, output logic [2:0] e, output int lat);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    check("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1; op_in = o; a_in = x; b_in = y;
    @(posedge clk); #1;
    in_valid = 1'b0; a_in = W'($urandom); b_in = W'($urandom); op_in = 4'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      check("in_ready_busy", in_ready, 0);
      @(posedge clk); #1; lat++;
    end
    res = r_out; e = err_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("retire_out_valid", out_valid, 0);
    check("retire_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [2*W-1:0] res, er;
    logic [2:0]     e, ee;
    int             lat, el;
    logic [3:0]     ops[7];
    logic [3:0]     o;
    logic [W-1:0]   x, y;

    tbl[0]  = '{4'b0000, 16'd9,     16'd6,     32'h0000000F, 3'b000, 1};
    tbl[1]  = '{4'b1000, 16'h8000,  16'h0001,  32'h00007FFF, 3'b001, 1};
    tbl[2]  = '{4'b1000, 16'd9,     16'd6,     32'h00000003, 3'b000, 1};
    tbl[3]  = '{4'b0100, 16'h7D00,  16'h0384,  32'h01B77400, 3'b000, 17};
    tbl[4]  = '{4'b0010, 16'd32000, 16'd900,   32'd35,       3'b000, 17};
    tbl[5]  = '{4'b0001, 16'd32000, 16'd900,   32'h000001F4, 3'b000, 17};
    tbl[6]  = '{4'b0010, 16'h1234,  16'h0000,  32'hFFFFFFFF, 3'b010, 1};
    tbl[7]  = '{4'b0001, 16'h1234,  16'h0000,  32'hFFFFFFFF, 3'b010, 1};
    tbl[8]  = '{4'b0011, 16'h00AA,  16'h0055,  32'h00000000, UNSUP,  1};
    tbl[9]  = '{4'b0000, 16'h7FFF,  16'h0001,  32'hFFFF8000, 3'b001, 1};
    tbl[10] = '{4'b0100, 16'hFFFF,  16'hFFFF,  32'hFFFE0001, 3'b000, 17};
    tbl[11] = '{4'b0010, 16'hFFFF,  16'h0001,  32'h0000FFFF, 3'b000, 17};
    tbl[12] = '{4'b0001, 16'd5,     16'd7,     32'h00000005, 3'b000, 17};
    tbl[13] = '{4'b0100, 16'h0000,  16'hBEEF,  32'h00000000, 3'b000, 17};
    tbl[14] = '{4'b1000, 16'h0000,  16'h0001,  32'hFFFFFFFF, 3'b000, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0; op_in = 4'b0000;
    #12;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_R", r_out, 0);
    check("reset_error", err_out, 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, res, e, lat);
      check($sformatf("vec%0d_R", i), res, tbl[i].r);
      check($sformatf("vec%0d_error", i), e, tbl[i].e);
      check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
    end

    ops = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0011, 4'b1111};
    for (int i = 0; i < 40; i++) begin
      o = ops[$urandom_range(0, 6)];
      x = W'($urandom);
      y = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      ref_model(o, x, y, er, ee, el);
      run_op(o, x, y, res, e, lat);
      check($sformatf("rnd%0d_R", i), res, er);
      check($sformatf("rnd%0d_error", i), e, ee);
      check($sformatf("rnd%0d_latency", i), lat, el);
    end

    // Backpressure: hold out_ready low for 5 cycles after a MUL completes.
    in_valid = 1'b1; op_in = 4'b0100; a_in = 16'h7D00; b_in = 16'h0384;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check("bp_latency", lat, 17);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_R_held", r_out, 32'h01B77400);
      check("bp_out_valid_held", out_valid, 1);
      check("bp_in_ready_low", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);

    // out_ready raised before out_valid must not retire early.
    out_ready = 1'b1; in_valid = 1'b1; op_in = 4'b0000; a_in = 16'd1; b_in = 16'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("early_ready_no_valid", out_valid, 0);
    @(posedge clk); #1;
    check("early_ready_valid", out_valid, 1);
    check("early_ready_R", r_out, 32'd3);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("early_ready_retired", out_valid, 0);
    check("early_ready_in_ready", in_ready, 1);

    // Reset in the middle of an EXEC.
    in_valid = 1'b1; op_in = 4'b0100; a_in = 16'h1234; b_in = 16'h5678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("midexec_busy", in_ready, 0);
    rst = 1'b1;
    #1;
    check("midexec_rst_out_valid", out_valid, 0);
    check("midexec_rst_in_ready", in_ready, 1);
    check("midexec_rst_R", r_out, 0);
    check("midexec_rst_error", err_out, 0);
    @(negedge clk); rst = 1'b0;
    run_op(4'b0000, 16'd100, 16'd23, res, e, lat);
    check("post_rst_R", res, 32'd123);
    check("post_rst_error", e, 0);
    check("post_rst_latency", lat, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
